// File: rtl/serial_adder_n.sv
// rtl/serial_adder_n.sv - bit-serial WIDTH-bit adder, LSB first, one full-adder cell
// Optional feature: define SERIAL_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_x;
  logic             fa_y;
  logic             fa_s;
  logic             fa_c;

  // Operand B and carry-in as they are captured on an accepted start
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  // The single full-adder cell, fed from the low end of the operand shifters
  assign fa_x = a_sr[0];
  assign fa_y = b_sr[0];
  assign fa_s = fa_x ^ fa_y ^ carry;
  assign fa_c = (fa_x & fa_y) | (fa_x & carry) | (fa_y & carry);

  // Control FSM and datapath registers; outputs are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // carry still holds the carry into the MSB at this point
            cout  <= fa_c;
            ovf   <= carry ^ fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE_S;
          end
        end
        DONE_S: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
